// File: rtl/serial_addsub_if.sv
// serial_addsub_if: start/busy/done handshake and operand/result bus for serial_addsub
interface serial_addsub_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDSUB_ACC_EN
  logic             acc;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDSUB_ACC_EN
    output acc,
`endif
    input  busy, done, sum, cout, ovf
  );
  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDSUB_ACC_EN
    input  acc,
`endif
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial LSB-first adder/subtractor; SERIAL_ADDSUB_ACC_EN takes A from sum when acc=1
module serial_addsub #(parameter int WIDTH = 4) (
  input  logic           clk,
  input  logic           reset,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, a_d;
  logic             c_q, cout_q, ovf_q, busy_q, done_q, s_d, c_d;
  // full-adder slice on the current operand LSBs and the carry FF
  always_comb begin
    s_d = a_q[0] ^ b_q[0] ^ c_q;
    c_d = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  end
`ifdef SERIAL_ADDSUB_ACC_EN
  assign a_d = bus.acc ? sum_q : bus.a;
`else
  assign a_d = bus.a;
`endif
  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_q     <= a_d;
          b_q     <= bus.b;
          c_q     <= bus.cin;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          sum_q <= {s_d, sum_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          if (cnt_q == CW'(WIDTH - 1)) begin
            ovf_q   <= c_q ^ c_d;
            cout_q  <= c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors with hand-computed results for serial_addsub
module tb_serial_addsub;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  serial_addsub_if #(.WIDTH(4)) bus();
  serial_addsub #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                    input logic tc, input logic [3:0] es, input logic ec, input logic eo);
    int nbusy;
    logic seen;
    nbusy = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb; bus.cin = tc;
    @(negedge clk);
    bus.start = 1'b0; bus.a = ~ta; bus.b = ~tb; bus.cin = ~tc;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.busy) nbusy++;
      @(negedge clk);
    end
    chk({tag, "_done"}, {7'b0, seen}, 8'd1);
    chk({tag, "_busycyc"}, 8'(nbusy), 8'd4);
    chk({tag, "_busy_at_done"}, {7'b0, bus.busy}, 8'd0);
    chk({tag, "_sum"}, {4'b0, bus.sum}, {4'b0, es});
    chk({tag, "_cout"}, {7'b0, bus.cout}, {7'b0, ec});
    chk({tag, "_ovf"}, {7'b0, bus.ovf}, {7'b0, eo});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {7'b0, bus.done}, 8'd0);
    chk({tag, "_sum_hold"}, {4'b0, bus.sum}, {4'b0, es});
  endtask

  initial begin
    int ndone, nbusy;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
`ifdef SERIAL_ADDSUB_ACC_EN
    bus.acc = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", {7'b0, bus.busy}, 8'd0);
    chk("rst_done", {7'b0, bus.done}, 8'd0);
    chk("rst_sum", {4'b0, bus.sum}, 8'd0);
    chk("rst_cout", {7'b0, bus.cout}, 8'd0);
    chk("rst_ovf", {7'b0, bus.ovf}, 8'd0);
    reset = 1'b0;
    op("add3p5", 4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1);
    op("sub7m2", 4'b0111, 4'b1101, 1'b1, 4'b0101, 1'b1, 1'b0);
    op("wrapF1", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    op("neg8m1", 4'b1000, 4'b1111, 1'b0, 4'b0111, 1'b1, 1'b1);
    op("add5p2", 4'b0101, 4'b0010, 1'b0, 4'b0111, 1'b0, 1'b0);
    // start re-pulsed during SHIFT with other operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b0110; bus.b = 4'b0011; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b1111; bus.b = 4'b1111; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0; nbusy = 2;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        ndone++;
        chk("ign_sum", {4'b0, bus.sum}, 8'h09);
        chk("ign_cout", {7'b0, bus.cout}, 8'd0);
        chk("ign_ovf", {7'b0, bus.ovf}, 8'd1);
      end
      if (bus.busy) nbusy++;
      @(negedge clk);
    end
    chk("ign_ndone", 8'(ndone), 8'd1);
    chk("ign_busycyc", 8'(nbusy), 8'd4);
    // reset in the second SHIFT cycle aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b0111; bus.b = 4'b0111; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {7'b0, bus.busy}, 8'd0);
    chk("abort_sum", {4'b0, bus.sum}, 8'd0);
    chk("abort_cout", {7'b0, bus.cout}, 8'd0);
    chk("abort_ovf", {7'b0, bus.ovf}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done || bus.busy) ndone++;
      @(negedge clk);
    end
    chk("abort_quiet", 8'(ndone), 8'd0);
    op("post_rst", 4'b0110, 4'b0101, 1'b1, 4'b1100, 1'b0, 1'b1);
`ifdef SERIAL_ADDSUB_ACC_EN
    bus.acc = 1'b0;
    op("acc0", 4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);
    bus.acc = 1'b1;
    op("acc1", 4'b1111, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0);
    bus.acc = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
